// File: rtl/jk_drive_ctrl.sv
// Drive controller for a bank of JK flip-flops: turns a target value into one-cycle
// J/K excitation, confirms the result through Q feedback and re-drives on mismatch.
module jk_drive_ctrl #(
    parameter int WIDTH       = 8,
    parameter int TOGGLE_PREF = 0,
    parameter int MAX_RETRY   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CHECK,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [3:0]       retry_q, retry_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mismatch;

    // JK excitation table per bit; returns {j, k}. Unmasked or matching bits hold.
    function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] tgt,
                                                  input logic [WIDTH-1:0] msk);
        logic [WIDTH-1:0] jx;
        logic [WIDTH-1:0] kx;
        jx = '0;
        kx = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (msk[b] && (cur[b] != tgt[b])) begin
                if (TOGGLE_PREF != 0) begin
                    jx[b] = 1'b1;
                    kx[b] = 1'b1;
                end else begin
                    jx[b] = tgt[b];
                    kx[b] = ~tgt[b];
                end
            end
        end
        return {jx, kx};
    endfunction

    assign mismatch = (q_fb ^ tgt_q) & mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            mask_q  <= '0;
            retry_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            mask_q  <= mask_d;
            retry_q <= retry_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // j/k are registered, so they are loaded on the edge that enters DRIVE and
    // cleared on the edge that leaves it.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        mask_d  = mask_q;
        retry_d = retry_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    tgt_d      = in_data;
                    mask_d     = in_mask;
                    retry_d    = '0;
                    {j_d, k_d} = excite(q_fb, in_data, in_mask);
                    state_d    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (mismatch == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d    = retry_q + 4'd1;
                    {j_d, k_d} = excite(q_fb, tgt_q, mask_q);
                    state_d    = S_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_ERROR: begin
                if (err_clr) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign j        = j_q;
    assign k        = k_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
